stopwatch_input_conditioner: RTL and testbench
==============================================

# stopwatch_input_conditioner

- Input-side front end for the stopwatch: turns the raw, asynchronous board controls into clean, synchronous signals for the stopwatch core.
- It synchronizes and debounces the pause button and the select/adjust switches.
- It produces a single-cycle pause press pulse and a registered pause toggle state.
- It sits between the board pins and `stopwatch`, on the main `clk` domain. It is the input counterpart of the display path.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles required to accept a new input level (10 ms at 100 MHz). Must be ≥1.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth per input. Must be ≥2.

Ports:
- `clk` input 1: main clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `pause_raw` input 1: raw pause pushbutton, asynchronous, bouncy.
- `select_raw` input 1: raw select switch, asynchronous.
- `adjust_raw` input 1: raw adjust switch, asynchronous.
- `pause_pulse` output 1: one-cycle pulse on each accepted pause press (debounced rising edge).
- `paused` output 1: pause state; toggles on every `pause_pulse`.
- `select` output 1: debounced select level.
- `adjust` output 1: debounced adjust level.

## Operation
- Each raw input goes through its own channel: `SYNC_STAGES`-deep synchronizer, then debounce FSM, then rising-edge detect.
- Debounce FSM states: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
  - STABLE_x: counter held at 0. If the synchronized value differs from the stable value, go to PEND.
  - PEND_x: counter increments each cycle the synchronized value still differs.
    - If it matches the stable value again (bounce), return to STABLE_x with counter cleared.
    - When the counter reaches `DEBOUNCE_CYCLES`-1 with the value still differing, the debounced output flips and the FSM enters the opposite STABLE state.
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1). The counter never wraps; it is cleared on every state exit.
- `pause_pulse` is high only on the cycle the debounced pause goes 0→1. A release (1→0) produces no pulse.
- `paused` flips on the same edge `pause_pulse` is registered high.
- `select`/`adjust` are levels only; no pulses.
- Reset values: all synchronizer flops 0, all FSMs STABLE_LOW, counters 0, `pause_pulse` 0, `paused` 0, `select` 0, `adjust` 0.
- Reset mid-debounce discards the pending transition. After reset release, an input still held high is accepted again through the full debounce delay. A held pause button therefore yields one `pause_pulse` after reset.
- Channels are independent. Simultaneous transitions on several inputs are each accepted on their own schedule.
- A button held indefinitely yields exactly one pulse.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Latency, raw edge to debounced output change: `SYNC_STAGES` + `DEBOUNCE_CYCLES` rising edges, counting from the first edge that samples the new raw level. The raw level must stay clean throughout.
- Any bounce restarts the full `DEBOUNCE_CYCLES` count from the first cycle of the final clean level.
- `pause_pulse` width: exactly 1 `clk` cycle.
- Minimum accepted press: `DEBOUNCE_CYCLES` cycles high after synchronization. Shorter glitches never reach the outputs.
- Two presses need a debounced release between them. The maximum pulse rate is one per 2·`DEBOUNCE_CYCLES` cycles.

## Structure
- Shared stopwatch package: `DEBOUNCE_CYCLES` default, a derived `CLK_HZ`-based constant, and the debounce FSM state encoding (2-bit enum).
- One natural sub-module: `debounce_channel`, containing synchronizer, FSM, counter, debounced level and rising-edge pulse outputs.
  - Instantiated three times.
  - The top adds only the `paused` toggle register.

## Test plan
Directed tests use `DEBOUNCE_CYCLES`=4 and `SYNC_STAGES`=2.
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 immediately, with no clock edge needed.
- **Clean press:** `pause_raw` 0→1 held → `pause_pulse` high for exactly one cycle, 6 edges after the first edge sampling 1; `paused` 0→1 on that edge. Release, then press again → `paused` 1→0.
- **Bounce:** `pause_raw` toggles 1,0,1,0 every cycle, then holds 1 → no pulse during the bounce; single pulse 6 edges after the last 0→1.
- **Glitch:** `select_raw` high for 3 cycles, then low → `select` stays 0.
- **Independence:** `select_raw` and `adjust_raw` rise on the same edge, with `adjust_raw` bouncing once → `select` rises at edge 6, `adjust` rises 6 edges after its final rise, `pause_pulse` stays 0.
- **Reset mid-operation:** hold `pause_raw`=1, assert `rst` at debounce count 2, release → no pulse before release; exactly one pulse 6 edges after the first post-reset edge; `paused`=1.

Source files
------------

// File: rtl/stopwatch_input_conditioner_pkg.sv
// Shared stopwatch constants: board clock, default debounce window and the
// encoding of the per-input debounce state machine.
package stopwatch_input_conditioner_pkg;

    localparam int CLK_HZ                  = 100_000_000;
    localparam int DEBOUNCE_MS             = 10;
    // 10 ms worth of board clock cycles (1_000_000 at 100 MHz).
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int SYNC_STAGES_DEFAULT     = 2;

    // Debounce FSM encoding. Bit 1 equals the accepted level in the STABLE
    // states and the level being left in the PEND states.
    typedef logic [1:0] db_state_t;
    localparam db_state_t DB_STABLE_LOW  = 2'b00;
    localparam db_state_t DB_PEND_HIGH   = 2'b01;
    localparam db_state_t DB_STABLE_HIGH = 2'b11;
    localparam db_state_t DB_PEND_LOW    = 2'b10;

endpackage

// File: rtl/stopwatch_input_conditioner_if.sv
// Board-control bundle: raw pin levels in, conditioned strobes/levels out.
interface stopwatch_input_conditioner_if;

    logic pause_raw;
    logic select_raw;
    logic adjust_raw;
    logic pause_pulse;
    logic paused;
    logic select;
    logic adjust;

    // Board / testbench side: drives raw pins, observes conditioned outputs.
    modport master (
        output pause_raw, select_raw, adjust_raw,
        input  pause_pulse, paused, select, adjust
    );

    // Conditioner side.
    modport slave (
        input  pause_raw, select_raw, adjust_raw,
        output pause_pulse, paused, select, adjust
    );

endinterface

// File: rtl/stopwatch_input_conditioner_debounce_channel.sv
// One input channel: N-stage synchronizer, four-state debounce FSM with a
// saturating-free counter, registered debounced level and rising-edge pulse.
module debounce_channel
    import stopwatch_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_pulse,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that moves STABLE->PEND is the first differing cycle, so the
    // flip happens when the counter is about to reach DEBOUNCE_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES >= 2) ? (DEBOUNCE_CYCLES - 2) : 0);
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_pulse;

    logic                   w_sync;
    db_state_t              w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_level_nxt;
    logic                   w_rise;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Metastability synchronizer: shift the raw pin through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Debounce next-state: any bounce back to the stable level restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_level_nxt = r_level;
        w_rise      = 1'b0;
        case (r_state)
            DB_STABLE_LOW: begin
                if (w_sync && SINGLE_CYCLE) begin
                    w_state_nxt = DB_STABLE_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise      = 1'b1;
                end else if (w_sync) begin
                    w_state_nxt = DB_PEND_HIGH;
                end else begin
                    w_state_nxt = DB_STABLE_LOW;
                end
            end
            DB_PEND_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = DB_STABLE_LOW;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_STABLE_HIGH;
                    w_level_nxt = 1'b1;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DB_STABLE_HIGH: begin
                if (!w_sync && SINGLE_CYCLE) begin
                    w_state_nxt = DB_STABLE_LOW;
                    w_level_nxt = 1'b0;
                end else if (!w_sync) begin
                    w_state_nxt = DB_PEND_LOW;
                end else begin
                    w_state_nxt = DB_STABLE_HIGH;
                end
            end
            DB_PEND_LOW: begin
                if (w_sync) begin
                    w_state_nxt = DB_STABLE_HIGH;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = DB_STABLE_LOW;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_nxt = DB_STABLE_LOW;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    // FSM, counter, debounced level and one-cycle rise pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DB_STABLE_LOW;
            r_cnt   <= {CNT_W{1'b0}};
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_rise;
        end
    end

    assign o_level = r_level;
    assign o_pulse = r_pulse;
    // Same-cycle strobe of the edge that registers o_pulse, for state that must
    // update on that very edge.
    assign o_rise  = w_rise;

endmodule

// File: rtl/stopwatch_input_conditioner.sv
// Stopwatch input front end: three independent debounce channels plus the
// pause toggle register.
module stopwatch_input_conditioner
    import stopwatch_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    stopwatch_input_conditioner_if.slave bus
);

    logic w_pause_level;
    logic w_pause_rise;
    logic w_sel_pulse;
    logic w_sel_rise;
    logic w_adj_pulse;
    logic w_adj_rise;
    logic w_unused_edges;
    logic r_paused;

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_pause (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.pause_raw),
        .o_level (w_pause_level),
        .o_pulse (bus.pause_pulse),
        .o_rise  (w_pause_rise)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_select (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.select_raw),
        .o_level (bus.select),
        .o_pulse (w_sel_pulse),
        .o_rise  (w_sel_rise)
    );

    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_adjust (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (bus.adjust_raw),
        .o_level (bus.adjust),
        .o_pulse (w_adj_pulse),
        .o_rise  (w_adj_rise)
    );

    // Select/adjust are consumed as levels only; their edge outputs are dropped.
    assign w_unused_edges = ^{w_pause_level, w_sel_pulse, w_sel_rise, w_adj_pulse, w_adj_rise};

    // Pause toggle: flips on the same edge that registers pause_pulse high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_paused <= 1'b0;
        end else if (w_pause_rise) begin
            r_paused <= ~r_paused;
        end else begin
            r_paused <= r_paused;
        end
    end

    assign bus.paused = r_paused;

endmodule

// File: tb/tb_stopwatch_input_conditioner.sv
// Directed bench for stopwatch_input_conditioner (DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2). Expected output events are queued with their cycle number
// when stimulus is driven; a negedge monitor pops them as the DUT produces them.
module tb_stopwatch_input_conditioner;

    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int LAT = DB + SS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   exp_paused = 1'b0;
    logic prev_sel = 1'b0;
    logic prev_adj = 1'b0;

    int pulse_q[$];
    int sel_q[$];
    int adj_q[$];

    stopwatch_input_conditioner_if bus ();

    stopwatch_input_conditioner #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse and every select/adjust level change must
    // match the next queued expected cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_sel = 1'b0;
            prev_adj = 1'b0;
        end else begin
            if (bus.pause_pulse === 1'b1) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    errors++;
                    $display("FAIL pause_pulse_event got pulse at cycle %0d expected none", cyc);
                end else begin
                    int e;
                    e = pulse_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL pause_pulse_cycle got %0d expected %0d", cyc, e);
                    end
                end
            end
            if (bus.select !== prev_sel) begin
                checks++;
                if (sel_q.size() == 0) begin
                    errors++;
                    $display("FAIL select_event got change to %0b at cycle %0d expected none", bus.select, cyc);
                end else begin
                    int e;
                    e = sel_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL select_cycle got %0d expected %0d", cyc, e);
                    end
                end
                prev_sel = bus.select;
            end
            if (bus.adjust !== prev_adj) begin
                checks++;
                if (adj_q.size() == 0) begin
                    errors++;
                    $display("FAIL adjust_event got change to %0b at cycle %0d expected none", bus.adjust, cyc);
                end else begin
                    int e;
                    e = adj_q.pop_front();
                    if (cyc !== e) begin
                        errors++;
                        $display("FAIL adjust_cycle got %0d expected %0d", cyc, e);
                    end
                end
                prev_adj = bus.adjust;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.pause_raw  = 1'b0;
        bus.select_raw = 1'b0;
        bus.adjust_raw = 1'b0;
        rst = 1'b1;
        step(3);
        checks++;
        if ({bus.pause_pulse, bus.paused, bus.select, bus.adjust} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0000", {bus.pause_pulse, bus.paused, bus.select, bus.adjust});
        end
        #1 rst = 1'b0;
        step(8);
        checks++;
        if ({bus.pause_pulse, bus.paused, bus.select, bus.adjust} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_outputs got %b expected 0000", {bus.pause_pulse, bus.paused, bus.select, bus.adjust});
        end
    endtask

    task automatic test_clean_press();
        for (int k = 0; k < 2; k++) begin
            int n;
            n = cyc;
            bus.pause_raw = 1'b1;
            pulse_q.push_back(n + LAT);
            step(LAT - 1);
            checks++;
            if (bus.paused !== exp_paused) begin
                errors++;
                $display("FAIL press%0d_paused_before got %b expected %b", k, bus.paused, exp_paused);
            end
            step(1);
            exp_paused = ~exp_paused;
            checks++;
            if (bus.paused !== exp_paused) begin
                errors++;
                $display("FAIL press%0d_paused_after got %b expected %b", k, bus.paused, exp_paused);
            end
            step(4);
            bus.pause_raw = 1'b0;
            step(LAT + 2);
        end
    endtask

    task automatic test_bounce();
        int n;
        bus.pause_raw = 1'b1; step(1);
        bus.pause_raw = 1'b0; step(1);
        bus.pause_raw = 1'b1; step(1);
        bus.pause_raw = 1'b0; step(1);
        n = cyc;
        bus.pause_raw = 1'b1;
        pulse_q.push_back(n + LAT);
        step(LAT - 1);
        checks++;
        if (bus.paused !== exp_paused) begin
            errors++;
            $display("FAIL bounce_paused_before got %b expected %b", bus.paused, exp_paused);
        end
        step(1);
        exp_paused = ~exp_paused;
        checks++;
        if (bus.paused !== exp_paused) begin
            errors++;
            $display("FAIL bounce_paused_after got %b expected %b", bus.paused, exp_paused);
        end
        step(3);
        bus.pause_raw = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_glitch();
        bus.select_raw = 1'b1;
        step(DB - 1);
        bus.select_raw = 1'b0;
        step(LAT + 4);
        checks++;
        if (bus.select !== 1'b0) begin
            errors++;
            $display("FAIL glitch_select got %b expected 0", bus.select);
        end
    endtask

    task automatic test_independence();
        int n;
        int m;
        n = cyc;
        bus.select_raw = 1'b1;
        bus.adjust_raw = 1'b1;
        sel_q.push_back(n + LAT);
        step(1);
        bus.adjust_raw = 1'b0;
        step(1);
        bus.adjust_raw = 1'b1;
        adj_q.push_back(n + 2 + LAT);
        step(LAT - 2);
        checks++;
        if ({bus.select, bus.adjust} !== 2'b10) begin
            errors++;
            $display("FAIL indep_mid got sel,adj=%b expected 10", {bus.select, bus.adjust});
        end
        step(2);
        checks++;
        if ({bus.select, bus.adjust} !== 2'b11) begin
            errors++;
            $display("FAIL indep_end got sel,adj=%b expected 11", {bus.select, bus.adjust});
        end
        step(2);
        m = cyc;
        bus.select_raw = 1'b0;
        bus.adjust_raw = 1'b0;
        sel_q.push_back(m + LAT);
        adj_q.push_back(m + LAT);
        step(LAT + 2);
        checks++;
        if ({bus.select, bus.adjust} !== 2'b00) begin
            errors++;
            $display("FAIL indep_release got sel,adj=%b expected 00", {bus.select, bus.adjust});
        end
    endtask

    task automatic test_reset_mid();
        int r;
        bus.pause_raw = 1'b1;
        // Debounce counter reaches 2 after the fifth edge.
        step(5);
        #1 rst = 1'b1;
        exp_paused = 1'b0;
        #1;
        checks++;
        if ({bus.pause_pulse, bus.paused} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_outputs got pulse,paused=%b expected 00", {bus.pause_pulse, bus.paused});
        end
        step(2);
        #1 rst = 1'b0;
        r = cyc;
        pulse_q.push_back(r + LAT);
        step(LAT - 1);
        checks++;
        if (bus.paused !== 1'b0) begin
            errors++;
            $display("FAIL midreset_paused_before got %b expected 0", bus.paused);
        end
        step(1);
        exp_paused = 1'b1;
        checks++;
        if (bus.paused !== exp_paused) begin
            errors++;
            $display("FAIL midreset_paused_after got %b expected %b", bus.paused, exp_paused);
        end
        // Button kept held: the monitor flags any further pulse.
        step(20);
    endtask

    task automatic test_async_reset();
        int n;
        n = cyc;
        bus.select_raw = 1'b1;
        bus.adjust_raw = 1'b1;
        sel_q.push_back(n + LAT);
        adj_q.push_back(n + LAT);
        step(LAT + 2);
        checks++;
        if ({bus.paused, bus.select, bus.adjust} !== 3'b111) begin
            errors++;
            $display("FAIL preasync_outputs got %b expected 111", {bus.paused, bus.select, bus.adjust});
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.pause_pulse, bus.paused, bus.select, bus.adjust} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset_outputs got %b expected 0000", {bus.pause_pulse, bus.paused, bus.select, bus.adjust});
        end
        bus.pause_raw  = 1'b0;
        bus.select_raw = 1'b0;
        bus.adjust_raw = 1'b0;
        step(3);
        #1 rst = 1'b0;
        step(LAT + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_independence();
        test_reset_mid();
        test_async_reset();
        checks++;
        if (pulse_q.size() + sel_q.size() + adj_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got %0d/%0d/%0d expected 0/0/0", pulse_q.size(), sel_q.size(), adj_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
